// File: rtl/block_matrix_multiplier_n.sv
// NxN signed matrix multiply / multiply-accumulate over a single-port RAM, built from 2x2 tiles
// with one 2x2 MAC, wide per-tile accumulators and saturating or wrapping write-back.
module block_matrix_multiplier_n #(
    parameter int DATA_W = 32,
    parameter int N      = 4,
    parameter int ADDR_W = 9,
    parameter int A_BASE = 0,
    parameter int B_BASE = 16,
    parameter int C_BASE = 32,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_acc,
    input  logic [DATA_W-1:0] ram_r_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_w_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int HB    = N / 2;
    localparam int IW    = (HB > 1) ? $clog2(HB) : 1;
    localparam int PW    = 2 * DATA_W;
    localparam int ACC_W = 2 * DATA_W + 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_C,
        S_LOAD_AB,
        S_DRAIN,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               cnt_q, cnt_d;
    logic [IW-1:0]            ti_q, ti_d, tj_q, tj_d, kb_q, kb_d;
    logic                     mode_q, mode_d;
    logic                     err_q, err_d;
    logic signed [DATA_W-1:0] a_q[4], a_d[4];
    logic signed [DATA_W-1:0] b_q[4], b_d[4];
    logic signed [ACC_W-1:0]  acc_q[4], acc_d[4];
    logic signed [PW-1:0]     prod_a[4], prod_b[4];

    logic [1:0]               cap_idx;
    logic                     last_k, last_tile, mac_clear;
    logic signed [ACC_W-1:0]  w_acc;
    logic [ACC_W-DATA_W:0]    w_hi;
    logic                     w_ovf;
    logic [DATA_W-1:0]        w_val;

    // Element e (0..3 = x11,x12,x21,x22) of 2x2 block (brow,bcol) of a row-major NxN matrix.
    function automatic logic [ADDR_W-1:0] elem_addr(input int base, input int brow,
                                                    input int bcol, input logic [1:0] e);
        int r;
        int c;
        r = 2 * brow + int'(e[1]);
        c = 2 * bcol + int'(e[0]);
        return ADDR_W'(base + r * N + c);
    endfunction

    // A word read arrives one cycle after its address, so it belongs to slot cnt_q-1.
    assign cap_idx   = cnt_q[1:0] - 2'd1;
    assign last_k    = (kb_q == IW'(HB - 1));
    assign last_tile = (ti_q == IW'(HB - 1)) && (tj_q == IW'(HB - 1));
    assign mac_clear = (kb_q == '0) && !mode_q;

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done = (state_q == S_DONE);
    assign err  = err_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            prod_a[i] = PW'(a_q[(i / 2) * 2]) * PW'(b_q[i % 2]);
            prod_b[i] = PW'(a_q[(i / 2) * 2 + 1]) * PW'(b_q[2 + (i % 2)]);
        end
    end

    // In range only when every bit above the DATA_W sign bit copies it.
    always_comb begin
        w_acc = acc_q[cnt_q[1:0]];
        w_hi  = w_acc[ACC_W-1:DATA_W-1];
        w_ovf = ~((&w_hi) | ~(|w_hi));
        if (w_ovf && (SAT != 0)) begin
            w_val = w_acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            w_val = w_acc[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ti_d       = ti_q;
        tj_d       = tj_q;
        kb_d       = kb_q;
        mode_d     = mode_q;
        err_d      = err_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_w_data = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode_acc;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    ti_d    = '0;
                    tj_d    = '0;
                    kb_d    = '0;
                    state_d = mode_acc ? S_LOAD_C : S_LOAD_AB;
                end
            end
            S_LOAD_C: begin
                if (cnt_q != 3'd4) begin
                    ram_addr = elem_addr(C_BASE, int'(ti_q), int'(tj_q), cnt_q[1:0]);
                end
                if (cnt_q != 3'd0) begin
                    acc_d[cap_idx] = ACC_W'($signed(ram_r_data));
                end
                if (cnt_q == 3'd4) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_AB;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_LOAD_AB: begin
                ram_addr = cnt_q[2] ? elem_addr(B_BASE, int'(kb_q), int'(tj_q), cnt_q[1:0])
                                    : elem_addr(A_BASE, int'(ti_q), int'(kb_q), cnt_q[1:0]);
                if (cnt_q > 3'd4) begin
                    b_d[cap_idx] = ram_r_data;
                end else if (cnt_q != 3'd0) begin
                    a_d[cap_idx] = ram_r_data;
                end
                if (cnt_q == 3'd7) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DRAIN: begin
                b_d[3]  = ram_r_data;
                state_d = S_MAC;
            end
            S_MAC: begin
                // First k block of a non-accumulating tile replaces instead of adding.
                for (int i = 0; i < 4; i++) begin
                    if (mac_clear) begin
                        acc_d[i] = ACC_W'(prod_a[i]) + ACC_W'(prod_b[i]);
                    end else begin
                        acc_d[i] = acc_q[i] + ACC_W'(prod_a[i]) + ACC_W'(prod_b[i]);
                    end
                end
                if (last_k) begin
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    kb_d    = kb_q + IW'(1);
                    state_d = S_LOAD_AB;
                end
            end
            S_WRITE: begin
                ram_we     = 1'b1;
                ram_addr   = elem_addr(C_BASE, int'(ti_q), int'(tj_q), cnt_q[1:0]);
                ram_w_data = w_val;
                if (w_ovf) begin
                    err_d = 1'b1;
                end
                if (cnt_q == 3'd3) begin
                    cnt_d = '0;
                    kb_d  = '0;
                    if (last_tile) begin
                        state_d = S_DONE;
                    end else begin
                        if (tj_q == IW'(HB - 1)) begin
                            tj_d = '0;
                            ti_d = ti_q + IW'(1);
                        end else begin
                            tj_d = tj_q + IW'(1);
                        end
                        state_d = mode_q ? S_LOAD_C : S_LOAD_AB;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ti_q    <= '0;
            tj_q    <= '0;
            kb_q    <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ti_q    <= ti_d;
            tj_q    <= tj_d;
            kb_q    <= kb_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_block_matrix_multiplier_n.sv
// Bench for block_matrix_multiplier_n: three instances (N=2 saturating, N=2 wrapping, N=4),
// each with its own registered-read RAM, driven from a vector table, random jobs and corner sequences.
module tb_block_matrix_multiplier_n;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int ND = 3;

    logic          clk = 1'b0;
    logic          rst[ND];
    logic          start[ND];
    logic          mode[ND];
    logic [DW-1:0] rdata[ND];
    logic [AW-1:0] addr[ND];
    logic          we[ND];
    logic [DW-1:0] wdata[ND];
    logic          busy[ND];
    logic          done[ND];
    logic          err[ND];
    logic [DW-1:0] mem[ND][512];
    int            wr_cnt[ND];
    int            oob_cnt[ND];
    int            total = 0;
    int            bad = 0;

    typedef struct packed {
        logic [1:0]        d;
        logic              mode;
        logic [15:0][31:0] a;
        logic [15:0][31:0] b;
        logic [15:0][31:0] c0;
        logic [15:0][31:0] cexp;
        logic              err;
        logic [7:0]        cyc;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < ND; g++) begin : g_dut
            block_matrix_multiplier_n #(
                .DATA_W(DW), .N((g == 2) ? 4 : 2), .ADDR_W(AW),
                .A_BASE(0), .B_BASE(16), .C_BASE(32), .SAT((g == 1) ? 0 : 1)
            ) u_dut (
                .clk       (clk),
                .rst       (rst[g]),
                .start     (start[g]),
                .mode_acc  (mode[g]),
                .ram_r_data(rdata[g]),
                .ram_addr  (addr[g]),
                .ram_we    (we[g]),
                .ram_w_data(wdata[g]),
                .busy      (busy[g]),
                .done      (done[g]),
                .err       (err[g])
            );
        end
    endgenerate

    function automatic int dim(input int d);
        return (d == 2) ? 4 : 2;
    endfunction

    function automatic bit sat_of(input int d);
        return (d == 1) ? 1'b0 : 1'b1;
    endfunction

    // Registered-read single-port RAMs; also count writes and writes outside the C matrix.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            rdata[d] <= mem[d][addr[d]];
            if (we[d] === 1'b1) begin
                mem[d][addr[d]] = wdata[d];
                wr_cnt[d] <= wr_cnt[d] + 1;
                if (int'(addr[d]) < 32 || int'(addr[d]) >= 32 + dim(d) * dim(d)) begin
                    oob_cnt[d] <= oob_cnt[d] + 1;
                end
            end
        end
    end

    function automatic logic [15:0][31:0] m2(input logic [31:0] x0, x1, x2, x3);
        logic [15:0][31:0] m;
        m    = '0;
        m[0] = x0;
        m[1] = x1;
        m[2] = x2;
        m[3] = x3;
        return m;
    endfunction

    function automatic vec_t mk(input int d, input logic md, input logic [15:0][31:0] a, b, c0,
                                cexp, input logic e, input int cyc);
        vec_t v;
        v.d = 2'(d); v.mode = md; v.a = a; v.b = b; v.c0 = c0;
        v.cexp = cexp; v.err = e; v.cyc = 8'(cyc);
        return v;
    endfunction

    // Plain full-matrix arithmetic: C[i][j] = (mode ? C0[i][j] : 0) + sum_k A[i][k]*B[k][j].
    task automatic modelC(input int d, input logic md, input logic [15:0][31:0] a, b, c0,
                          output logic [15:0][31:0] cexp, output logic e);
        int n;
        logic signed [79:0] s, pa, pb;
        n = dim(d);
        e = 1'b0;
        cexp = '0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = md ? {{48{c0[i*n+j][31]}}, c0[i*n+j]} : '0;
                for (int k = 0; k < n; k++) begin
                    pa = {{48{a[i*n+k][31]}}, a[i*n+k]};
                    pb = {{48{b[k*n+j][31]}}, b[k*n+j]};
                    s = s + pa * pb;
                end
                if (s > 80'sd2147483647 || s < -80'sd2147483648) begin
                    e = 1'b1;
                    if (sat_of(d)) cexp[i*n+j] = s[79] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    else           cexp[i*n+j] = s[31:0];
                end else begin
                    cexp[i*n+j] = s[31:0];
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic loadMem(input int d, input logic [15:0][31:0] a, b, c0);
        for (int i = 0; i < 16; i++) begin
            mem[d][i]      = a[i];
            mem[d][16 + i] = b[i];
            mem[d][32 + i] = c0[i];
        end
    endtask

    // One job: start is sampled at the next edge; cycles are counted from that edge to done.
    task automatic applyStimulus(input int d, input logic md, input int poke_at, output int cyc,
                                 output logic bz, output int nwr, output int noob);
        int w0, o0;
        w0 = wr_cnt[d];
        o0 = oob_cnt[d];
        @(negedge clk);
        mode[d]  = md;
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        cyc = 0;
        while (done[d] !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            start[d] = (cyc == poke_at);
        end
        start[d] = 1'b0;
        bz = busy[d];
        @(posedge clk);
        #1;
        nwr  = wr_cnt[d] - w0;
        noob = oob_cnt[d] - o0;
    endtask

    task automatic runVector(input vec_t v, input int poke_at, input string tag);
        int cyc, nwr, noob, n;
        logic bz;
        n = dim(int'(v.d));
        loadMem(int'(v.d), v.a, v.b, v.c0);
        applyStimulus(int'(v.d), v.mode, poke_at, cyc, bz, nwr, noob);
        checkOutput({tag, " cycles"}, 64'(cyc), 64'(v.cyc));
        checkOutput({tag, " busy@done"}, 64'(bz), 64'(0));
        checkOutput({tag, " err"}, 64'(err[v.d]), 64'(v.err));
        checkOutput({tag, " writes"}, 64'(nwr), 64'(n * n));
        checkOutput({tag, " stray writes"}, 64'(noob), 64'(0));
        for (int i = 0; i < n * n; i++) begin
            checkOutput($sformatf("%s C[%0d]", tag, i), 64'(mem[v.d][32 + i]), 64'(v.cexp[i]));
        end
    endtask

    initial begin
        logic [15:0][31:0] a4, id4, ra, rb, rc, rexp;
        logic re;
        int cyc, cyc2, d, n, nwr0;
        logic md;

        for (int i = 0; i < ND; i++) begin
            rst[i] = 1'b0; start[i] = 1'b0; mode[i] = 1'b0;
        end
        a4 = '0; id4 = '0;
        for (int i = 0; i < 16; i++) a4[i] = 32'(i + 1);
        for (int i = 0; i < 4; i++) id4[i*4+i] = 32'd1;

        vecs[0] = mk(0, 0, m2(1, 2, 3, 4), m2(5, 6, 7, 8), '0, m2(19, 22, 43, 50), 0, 14);
        vecs[1] = mk(2, 0, a4, id4, '0, a4, 0, 96);
        vecs[2] = mk(0, 1, m2(1, 0, 0, 1), m2(2, 3, 4, 5), m2(1, 1, 1, 1), m2(3, 4, 5, 6), 0, 19);
        vecs[3] = mk(0, 0, m2(32'h7FFF_FFFF, 0, 0, 0), m2(2, 0, 0, 0), '0, m2(32'h7FFF_FFFF, 0, 0, 0), 1, 14);
        vecs[4] = mk(1, 0, m2(32'h7FFF_FFFF, 0, 0, 0), m2(2, 0, 0, 0), '0, m2(32'hFFFF_FFFE, 0, 0, 0), 1, 14);
        vecs[5] = mk(1, 0, m2(32'h8000_0000, 0, 0, 0), m2(2, 0, 0, 0), '0, m2(0, 0, 0, 0), 1, 14);
        vecs[6] = mk(1, 0, m2(1, 2, 3, 4), m2(1, 0, 0, 1), '0, m2(1, 2, 3, 4), 0, 14);
        vecs[7] = mk(0, 0, m2(32'h8000_0000, 0, 0, 0), m2(2, 0, 0, 0), '0, m2(32'h8000_0000, 0, 0, 0), 1, 14);
        vecs[8] = mk(0, 0, m2(1, 2, 3, 4), m2(5, 6, 7, 8), '0, m2(19, 22, 43, 50), 0, 14);

        #2;
        for (int i = 0; i < ND; i++) begin
            checkOutput($sformatf("reset%0d busy", i), 64'(busy[i]), 64'(0));
            checkOutput($sformatf("reset%0d done", i), 64'(done[i]), 64'(0));
            checkOutput($sformatf("reset%0d err", i), 64'(err[i]), 64'(0));
            checkOutput($sformatf("reset%0d we", i), 64'(we[i]), 64'(0));
            checkOutput($sformatf("reset%0d addr", i), 64'(addr[i]), 64'(0));
            checkOutput($sformatf("reset%0d wdata", i), 64'(wdata[i]), 64'(0));
        end
        @(negedge clk);
        for (int i = 0; i < ND; i++) rst[i] = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 9; v++) runVector(vecs[v], -1, $sformatf("vec%0d", v));

        // A start pulse during LOAD_AB must not disturb the job.
        runVector(vecs[0], 3, "poke");

        // start held high: DONE ignores it, the following IDLE cycle accepts it.
        loadMem(0, vecs[0].a, vecs[0].b, vecs[0].c0);
        @(negedge clk);
        mode[0] = 1'b0;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        while (done[0] !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1; cyc++;
        end
        checkOutput("held first cycles", 64'(cyc), 64'(14));
        @(posedge clk); #1;
        checkOutput("held idle busy", 64'(busy[0]), 64'(0));
        @(posedge clk); #1;
        checkOutput("held restart busy", 64'(busy[0]), 64'(1));
        start[0] = 1'b0;
        cyc2 = 0;
        while (done[0] !== 1'b1 && cyc2 < 2000) begin
            @(posedge clk); #1; cyc2++;
        end
        checkOutput("held second cycles", 64'(cyc2), 64'(14));
        @(posedge clk); #1;
        checkOutput("held no third start", 64'(busy[0]), 64'(0));
        checkOutput("held C[3]", 64'(mem[0][35]), 64'(50));

        // Reset in the second LOAD_AB of the N=4 job: outputs drop at once, nothing is written.
        loadMem(2, a4, id4, '0);
        for (int i = 0; i < 16; i++) mem[2][32 + i] = 32'hDEAD_BEEF;
        nwr0 = wr_cnt[2];
        @(negedge clk);
        mode[2] = 1'b0;
        start[2] = 1'b1;
        @(posedge clk);
        #1;
        start[2] = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        checkOutput("rstmid busy before", 64'(busy[2]), 64'(1));
        rst[2] = 1'b0;
        #1;
        checkOutput("rstmid busy", 64'(busy[2]), 64'(0));
        checkOutput("rstmid we", 64'(we[2]), 64'(0));
        checkOutput("rstmid done", 64'(done[2]), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[2] = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        checkOutput("rstmid writes", 64'(wr_cnt[2] - nwr0), 64'(0));
        checkOutput("rstmid C[0] kept", 64'(mem[2][32]), 64'(32'hDEAD_BEEF));
        checkOutput("rstmid idle", 64'(busy[2]), 64'(0));
        runVector(vecs[1], -1, "after reset");

        // Random jobs on every instance against the full-matrix model.
        for (int t = 0; t < 12; t++) begin
            d  = t % 3;
            n  = dim(d);
            md = 1'($urandom % 2);
            ra = '0; rb = '0; rc = '0;
            for (int i = 0; i < n * n; i++) begin
                ra[i] = ($urandom % 4 == 0) ? 32'($urandom) : 32'($urandom_range(0, 200)) - 32'd100;
                rb[i] = ($urandom % 4 == 0) ? 32'($urandom) : 32'($urandom_range(0, 200)) - 32'd100;
                rc[i] = ($urandom % 3 == 0) ? 32'($urandom) : 32'($urandom_range(0, 200)) - 32'd100;
            end
            modelC(d, md, ra, rb, rc, rexp, re);
            runVector(mk(d, md, ra, rb, rc, rexp, re,
                         (n / 2) * (n / 2) * ((n / 2) * 10 + 4 + 5 * int'(md))),
                      -1, $sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_matrix_multiplier_n.md
Name: block_matrix_multiplier_n

Overview:
Parametrised successor of the fixed 2x2 matrix multiplier top level. It computes C = A x B, or C = C + A x B in accumulate mode, for square NxN signed matrices held row-major in an external single-port RAM. The product is formed tile by tile from 2x2 sub-blocks using one internal 2x2 tile MAC and wide per-tile accumulators. Each result is written back with selectable saturation and a sticky overflow flag.

Parameters:
DATA_W, 32, element width, signed two's complement
N, 4, matrix dimension; even, >=2
ADDR_W, 9, RAM word-address width
A_BASE, 0, word address of A[0][0]
B_BASE, 16, word address of B[0][0]
C_BASE, 32, word address of C[0][0]
SAT, 1, 1 = saturate on write-back; 0 = truncate (wrap)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin operation; sampled only in IDLE
mode_acc  in  1  0: C=AxB; 1: C=C+AxB; latched with start
ram_r_data  in  DATA_W  RAM read data, valid one cycle after address
ram_addr  out  ADDR_W  RAM word address
ram_we  out  1  RAM write enable
ram_w_data  out  DATA_W  RAM write data
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse on completion
err  out  1  sticky overflow flag; cleared by next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy, done, err, ram_we = 0; ram_addr, ram_w_data = 0; accumulators and tile registers = 0. Reset mid-operation abandons the job with no further RAM writes. Words already written stay written.
- Address map: X[i][j] lives at X_BASE + i*N + j.
- FSM states: IDLE -> (LOAD_C if mode_acc) -> LOAD_AB -> DRAIN -> MAC -> (LOAD_AB for the next k block | WRITE) -> next tile, or DONE -> IDLE.
- Tile loop: tile (ti,tj) in row-major order, ti,tj in 0..N/2-1. Inner loop over k block 0..N/2-1.
- Tile start, mode_acc=0: accumulators cleared with no extra cycle.
- Tile start, mode_acc=1, LOAD_C: 4 address cycles (C11,C12,C21,C22) plus 1 drain cycle. Data is sign-extended into the accumulators.
- LOAD_AB: 8 consecutive address cycles, order A11,A12,A21,A22,B11,B12,B21,B22 of the current blocks. Data is captured the cycle after each address. DRAIN captures the last word.
- MAC (1 cycle): acc_rc += A_r1*B_1c + A_r2*B_2c, full-precision signed. Accumulator width is 2*DATA_W+8.
- WRITE: 4 cycles with ram_we=1, order C11,C12,C21,C22.
- Write-back out of signed DATA_W range: SAT=1 writes the clamped value 0x7F..F or 0x80..0. SAT=0 writes the low DATA_W bits. In both cases err is set.
- Cycle count from the cycle after start to the done pulse: (N/2)^2 * (N/2*10 + 4 + 5*mode_acc). For N=2, mode_acc=0 this is 14.
- done pulses in the cycle after the last write. busy falls in the same cycle.
- ram_we is 0 in every state except WRITE.
- start while busy: ignored; no restart and no err.
- start coincident with done: ignored. A new start is accepted from the next IDLE cycle.
- start held high continuously: restarts one cycle after done.
- N=2: a single tile with a single k block.

Test Plan:
- N=2, mode_acc=0, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]]. done on cycle 14. err=0. Exactly 4 writes, to addresses 32..35.
- N=4, mode_acc=0, A = 4x4 values 1..16, B = identity -> C equals A. done at cycle 4*(20+4)=96.
- N=2, mode_acc=1, C preloaded [[1,1],[1,1]], A=I, B=[[2,3],[4,5]] -> C=[[3,4],[5,6]]. done at cycle 19.
- N=2, SAT=1: A11=0x7FFFFFFF, B11=2, all else 0 -> C11=0x7FFFFFFF, err=1. Same stimulus with SAT=0 -> C11=0xFFFFFFFE, err=1. A following clean start clears err.
- Pulse start again during LOAD_AB -> no restart. Cycle count and results unchanged.
- Drive rst=0 during the 2nd LOAD_AB of N=4 -> ram_we, busy, done = 0 immediately and no writes follow. A new start after reset produces correct results.
